external_bus_responder: RTL

// - Far end of the CPU external bus. Answers the core's address/data-bus reads and writes from a local byte RAM.
// - Exposes a memory-mapped UART window. It drains TX bytes to the board UART and captures RX bytes into a FIFO.
// - Sits in top beside internalDataflow; it supplies the byte stream that instructionLoader and the core consume.

---
 rtl/external_bus_responder_pkg.sv | 15 +
 rtl/external_bus_responder_if.sv | 15 +
 rtl/external_bus_responder_byte_fifo.sv | 42 ++++
 rtl/external_bus_responder.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/external_bus_responder_pkg.sv
// Shared definitions for the external bus responder: UART register map, status bits, FSM states.
package responder_pkg;

  localparam logic [1:0] UART_DATA    = 2'd0;
  localparam logic [1:0] UART_STATUS  = 2'd1;
  localparam logic [1:0] UART_CONTROL = 2'd2;

  localparam int unsigned STAT_TXFULL  = 0;
  localparam int unsigned STAT_RXNE    = 1;
  localparam int unsigned STAT_OVERRUN = 2;

  typedef enum logic [1:0] {TX_IDLE, TX_STROBE, TX_HOLD} txState_t;
  typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_WAIT} rxState_t;

endpackage

// File: rtl/external_bus_responder_if.sv
// Core-side external address/data bus seen by the responder.
interface external_bus_responder_if;
  logic [7:0] addrLow;
  logic [7:0] addrHigh;
  logic [7:0] dbWrite;
  logic       writeEnable;
  logic       readEnable;
  logic [7:0] dbRead;
  logic       readValid;

  modport master (output addrLow, addrHigh, dbWrite, writeEnable, readEnable,
                  input  dbRead, readValid);
  modport slave  (input  addrLow, addrHigh, dbWrite, writeEnable, readEnable,
                  output dbRead, readValid);
endinterface

// File: rtl/external_bus_responder_byte_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; a pop on the same edge frees room for a push when full.
module byte_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head_c,
  output logic             full_c,
  output logic             empty_c
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_c = (wptr == rptr);
  assign full_c  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty_c;
  assign do_push = push && (!full_c || do_pop);
  assign head_c  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/external_bus_responder.sv
// Far end of the CPU external bus: byte RAM plus a 4-register UART window with TX/RX FIFOs.
// Optional feature macro: RESPONDER_IRQ_EN enables the CONTROL register and the irq output.
module external_bus_responder
  import responder_pkg::*;
#(
  parameter int unsigned RAM_ADDR_BITS = 8,
  parameter logic [15:0] UART_BASE     = 16'hFF00,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  external_bus_responder_if.slave   bus,
  output logic [7:0]                txdata,
  output logic                      txclk,
  input  logic                      txready,
  input  logic [7:0]                rxdata,
  output logic                      rxclk,
  input  logic                      rxready,
  output logic                      irq
);
  localparam int unsigned RAM_SIZE = 1 << RAM_ADDR_BITS;

  logic [7:0]  ram [RAM_SIZE];
  logic [15:0] addr;
  logic [1:0]  off;
  logic        uart_sel, wr_c, rd_c, stat_rd_c;
  logic [7:0]  rd_data_c, status_c;
  logic        overrun, irq_enable;

  logic       tx_push_c, tx_pop_c, tx_full_c, tx_empty_c;
  logic       rx_push_c, rx_pop_c, rx_full_c, rx_empty_c;
  logic [7:0] tx_head_c, rx_head_c;
  txState_t   tx_state, tx_next;
  rxState_t   rx_state, rx_next;

  // Address decode and write-over-read priority
  assign addr      = {bus.addrHigh, bus.addrLow};
  assign off       = addr[1:0];
  assign uart_sel  = ({1'b0, addr} >= 17'(UART_BASE)) && ({1'b0, addr} <= 17'(UART_BASE) + 17'd3);
  assign wr_c      = bus.writeEnable;
  assign rd_c      = bus.readEnable && !bus.writeEnable;
  assign stat_rd_c = rd_c && uart_sel && (off == UART_STATUS);
  assign tx_push_c = wr_c && uart_sel && (off == UART_DATA);
  assign rx_pop_c  = rd_c && uart_sel && (off == UART_DATA);

  byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push_c), .pop(tx_pop_c), .din(bus.dbWrite),
    .head_c(tx_head_c), .full_c(tx_full_c), .empty_c(tx_empty_c)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push_c), .pop(rx_pop_c), .din(rxdata),
    .head_c(rx_head_c), .full_c(rx_full_c), .empty_c(rx_empty_c)
  );

  always_ff @(posedge clk) begin
    if (wr_c && !uart_sel) ram[addr[RAM_ADDR_BITS-1:0]] <= bus.dbWrite;
  end

  always_comb begin
    status_c               = '0;
    status_c[STAT_TXFULL]  = tx_full_c;
    status_c[STAT_RXNE]    = !rx_empty_c;
    status_c[STAT_OVERRUN] = overrun;
  end

  always_comb begin
    rd_data_c = ram[addr[RAM_ADDR_BITS-1:0]];
    if (uart_sel) begin
      case (off)
        UART_DATA:    rd_data_c = rx_empty_c ? 8'h00 : rx_head_c;
        UART_STATUS:  rd_data_c = status_c;
        UART_CONTROL: rd_data_c = {7'b0, irq_enable};
        default:      rd_data_c = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.dbRead    <= 8'h00;
      bus.readValid <= 1'b0;
    end else begin
      bus.readValid <= rd_c;
      if (rd_c) bus.dbRead <= rd_data_c;
    end
  end

  // A drop on the same edge as a STATUS read keeps overrun set
  always_ff @(posedge clk) begin
    if (rst)                                    overrun <= 1'b0;
    else if (rx_push_c && rx_full_c && !rx_pop_c) overrun <= 1'b1;
    else if (stat_rd_c)                         overrun <= 1'b0;
  end

`ifdef RESPONDER_IRQ_EN
  logic ctrl_wr_c;
  assign ctrl_wr_c = wr_c && uart_sel && (off == UART_CONTROL);

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_enable <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (ctrl_wr_c) irq_enable <= bus.dbWrite[0];
      irq <= irq_enable && (!rx_empty_c || overrun);
    end
  end
`else
  assign irq_enable = 1'b0;
  assign irq        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      txclk    <= 1'b0;
      txdata   <= 8'h00;
    end else begin
      tx_state <= tx_next;
      txclk    <= (tx_next == TX_STROBE);
      if (tx_pop_c) txdata <= tx_head_c;
    end
  end

  always_comb begin
    tx_next  = tx_state;
    tx_pop_c = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!tx_empty_c && txready) begin
          tx_next  = TX_STROBE;
          tx_pop_c = 1'b1;
        end
      end
      TX_STROBE: tx_next = TX_HOLD;
      TX_HOLD:   tx_next = TX_IDLE;
      default:   tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rxclk    <= 1'b0;
    end else begin
      rx_state <= rx_next;
      rxclk    <= (rx_next == RX_ACK);
    end
  end

  // RX_WAIT holds off until rxready drops so each assertion is taken once
  always_comb begin
    rx_next   = rx_state;
    rx_push_c = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rxready) begin
          rx_next   = RX_ACK;
          rx_push_c = 1'b1;
        end
      end
      RX_ACK:  rx_next = RX_WAIT;
      RX_WAIT: if (!rxready) rx_next = RX_IDLE;
      default: rx_next = RX_IDLE;
    endcase
  end
endmodule
